pin_capt: RTL and testbench

// - Pin-event capture / time-stamp block for an asynchronous single-bit input.
// - Samples pin_in on every clk600 edge and synchronises it.
// - Detects rising edges; reports each with a one-cycle strobe and a 3-bit

---
 rtl/pin_capt.sv | 99 +++++++++
 tb/tb_pin_capt.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pin_capt.sv
// pin_capt: synchronises an asynchronous pin, detects its rising edges and
// tags each one with the slot of a free-running 2**TW-cycle frame in which
// the edge was first sampled. Downstream timing logic rebuilds the arrival
// window as (now - 2 clk periods - slot offset), so the 2-cycle latency from
// first high sample to str/ptime must stay fixed.
`timescale 1ns/1ps

module pin_capt #(
   parameter int unsigned TW = 3
) (
   input  logic          clk600,
   input  logic          rst_n,
   input  logic          pin_in,
   output logic          pin_out,
   output logic          str,
   output logic [TW-1:0] ptime
);

   // Slot counter and its pipeline copies.
   logic [TW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] t1_q,  t1_d;
   logic [TW-1:0] t2_q,  t2_d;

   // Synchroniser chain: s1 captures metastability and feeds only s2;
   // s2 is the first stable stage and s3 is its one-cycle-old copy.
   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          s3_q, s3_d;

   // Output registers.
   logic          pin_out_q, pin_out_d;
   logic          str_q,     str_d;
   logic [TW-1:0] ptime_q,   ptime_d;

   // Rising edge seen on the stable stage.
   logic          rise_c;

   assign rise_c = s2_q & ~s3_q;

   // Next-state logic: counter, sync/tag pipeline and output updates.
   always_comb begin
      cnt_d     = cnt_q;
      t1_d      = t1_q;
      t2_d      = t2_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      s3_d      = s3_q;
      pin_out_d = pin_out_q;
      str_d     = str_q;
      ptime_d   = ptime_q;

      // Free-running frame counter, wraps naturally at 2**TW.
      cnt_d     = cnt_q + TW'(1);

      // The tag travels alongside the pin sample so it matches the slot
      // where the sample was taken (pre-increment counter value).
      s1_d      = pin_in;
      t1_d      = cnt_q;
      s2_d      = s1_q;
      t2_d      = t1_q;
      s3_d      = s2_q;

      pin_out_d = s2_q;
      str_d     = rise_c;
      if (rise_c) begin
         ptime_d = t2_q;
      end
   end

   // State register with asynchronous clear; any event in flight is dropped.
   always_ff @(posedge clk600 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         t1_q      <= '0;
         t2_q      <= '0;
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         pin_out_q <= 1'b0;
         str_q     <= 1'b0;
         ptime_q   <= '0;
      end else begin
         cnt_q     <= cnt_d;
         t1_q      <= t1_d;
         t2_q      <= t2_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         s3_q      <= s3_d;
         pin_out_q <= pin_out_d;
         str_q     <= str_d;
         ptime_q   <= ptime_d;
      end
   end

   assign pin_out = pin_out_q;
   assign str     = str_q;
   assign ptime   = ptime_q;

endmodule

// File: tb/tb_pin_capt.sv
// Directed bench for pin_capt: reset, single edge, slot sweep with wrap,
// fast toggle, sub-period glitch, mid-strobe reset and high pin at release.
`timescale 1ns/1ps

module tb_pin_capt;

   logic       clk600;
   logic       rst_n;
   logic       pin_in;
   logic       pin_out;
   logic       str;
   logic [2:0] ptime;

   int n_checks;
   int n_errors;
   int ecnt;      // index of the next rising clk edge since reset release

   pin_capt #(.TW(3)) dut (
      .clk600  (clk600),
      .rst_n   (rst_n),
      .pin_in  (pin_in),
      .pin_out (pin_out),
      .str     (str),
      .ptime   (ptime)
   );

   // 100 MHz stand-in clock, rising edges at 5, 15, 25 ns ...
   initial begin
      clk600 = 1'b0;
      forever #5 clk600 = ~clk600;
   end

   // Single comparison point.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_str, input logic e_pout,
                          input logic [2:0] e_ptime);
      chk({tag, ".str"},     32'(str),     32'(e_str));
      chk({tag, ".pin_out"}, 32'(pin_out), 32'(e_pout));
      chk({tag, ".ptime"},   32'(ptime),   32'(e_ptime));
   endtask

   // Advance n rising edges and settle 1 ns after the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk600);
         #1;
         ecnt++;
      end
   endtask

   task automatic align(input int slot);
      for (int i = 0; i < 8; i++) begin
         if (ecnt % 8 != slot) tick(1);
      end
   endtask

   // One-cycle-high pulse sampled on the next edge; expects one strobe.
   task automatic send_pulse(input string tag, input logic [2:0] exp_slot,
                             input logic [2:0] prev_ptime);
      pin_in = 1'b1;
      tick(1);
      pin_in = 1'b0;
      chk_out({tag, ".e0"}, 1'b0, 1'b0, prev_ptime);
      tick(1);
      chk_out({tag, ".e1"}, 1'b0, 1'b0, prev_ptime);
      tick(1);
      chk_out({tag, ".e2"}, 1'b1, 1'b1, exp_slot);
      tick(1);
      chk_out({tag, ".e3"}, 1'b0, 1'b0, exp_slot);
   endtask

   initial begin
      logic [2:0] sweep_exp [9];
      logic [2:0] prev;
      int         f;
      int         strobes;
      int         k;

      n_checks = 0;
      n_errors = 0;
      ecnt     = 0;
      rst_n    = 1'b0;
      pin_in   = 1'b0;

      // Reset held with the pin toggling: outputs stay clear.
      #1;
      chk_out("rst0", 1'b0, 1'b0, 3'd0);
      for (int i = 0; i < 6; i++) begin
         pin_in = ~pin_in;
         tick(1);
         chk_out("rst_hold", 1'b0, 1'b0, 3'd0);
      end

      // Release between edges; edge 0 samples cnt=0.
      pin_in = 1'b0;
      rst_n  = 1'b1;
      ecnt   = 0;

      // Single edge: pin rises between edges 2 and 3.
      tick(3);
      pin_in = 1'b1;
      tick(1);
      chk_out("single.e3", 1'b0, 1'b0, 3'd0);
      tick(1);
      chk_out("single.e4", 1'b0, 1'b0, 3'd0);
      tick(1);
      chk_out("single.e5", 1'b1, 1'b1, 3'd3);
      tick(1);
      chk_out("single.e6", 1'b0, 1'b1, 3'd3);
      pin_in = 1'b0;
      tick(3);
      chk_out("single.fall", 1'b0, 1'b0, 3'd3);

      // Slot sweep: pulses 9 cycles apart advance the slot by one; last wraps.
      sweep_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      align(0);
      prev = 3'd3;
      for (int p = 0; p < 9; p++) begin
         send_pulse((p == 8) ? "wrap" : "sweep", sweep_exp[p], prev);
         prev = sweep_exp[p];
         tick(5);
      end

      // Fast toggle from slot 3: 8 strobes, ptime 3,3,5,5,7,7,1,1,...
      align(3);
      f       = ecnt;
      strobes = 0;
      for (int i = 0; i < 18; i++) begin
         pin_in = (i < 16) && (i % 2 == 0);
         tick(1);
         strobes += int'(str);
         if (i < 2) begin
            chk_out("toggle.lead", 1'b0, 1'b0, 3'd0);
         end else begin
            k = i - 2;
            chk_out("toggle", (k % 2 == 0), (k % 2 == 0), 3'((f + k - (k % 2)) % 8));
         end
      end
      chk("toggle.count", 32'(strobes), 32'd8);

      // Sub-period glitch between edges: nothing reported, ptime holds 1.
      #2 pin_in = 1'b1;
      #0.4 pin_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk_out("glitch", 1'b0, 1'b0, 3'd1);
      end

      // Reset mid-strobe with a second rise already in the pipeline.
      align(5);
      pin_in = 1'b1;
      tick(1);
      pin_in = 1'b0;
      tick(1);
      pin_in = 1'b1;
      tick(1);
      chk_out("midrst.pre", 1'b1, 1'b1, 3'd5);
      rst_n = 1'b0;
      #1;
      chk_out("midrst.async", 1'b0, 1'b0, 3'd0);
      pin_in = 1'b0;
      tick(2);
      rst_n = 1'b1;
      ecnt  = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk_out("midrst.discard", 1'b0, 1'b0, 3'd0);
      end

      // Pin already high at release: first sample counts as a rise at slot 0.
      rst_n  = 1'b0;
      pin_in = 1'b1;
      tick(2);
      rst_n  = 1'b1;
      ecnt   = 0;
      tick(1);
      chk_out("relhigh.e0", 1'b0, 1'b0, 3'd0);
      tick(1);
      chk_out("relhigh.e1", 1'b0, 1'b0, 3'd0);
      tick(1);
      chk_out("relhigh.e2", 1'b1, 1'b1, 3'd0);
      tick(1);
      chk_out("relhigh.e3", 1'b0, 1'b1, 3'd0);
      pin_in = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
